// File: rtl/oam_dma_pkg.sv
// Shared definitions for the sprite DMA engine: state encodings, default
// bus addresses, read/write encoding and the address-generator select.
package oam_dma_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HALT  = 3'd1,
      ALIGN = 3'd2,
      GET   = 3'd3,
      PUT   = 3'd4
   } state_t;

   // Default trigger register and OAM data port addresses.
   localparam logic [15:0] DMA_REG_DEF  = 16'h4014;
   localparam logic [15:0] OAM_DATA_DEF = 16'h2004;

   // Bus read/write encoding shared with the 6502 core.
   localparam logic RW_R = 1'b1;
   localparam logic RW_W = 1'b0;

   // Which address the generator presents in the next cycle.
   typedef enum logic [1:0] {
      SEL_HOLD = 2'd0,   // keep the current bus_a
      SEL_BASE = 2'd1,   // {page, 8'h00} dummy read
      SEL_SRC  = 2'd2,   // {page, idx} source read
      SEL_OAM  = 2'd3    // OAM data port write
   } addr_sel_t;

endpackage

// File: rtl/oam_dma_addr_gen.sv
// Page register, byte index and registered DMA address output.
module dma_addr_gen
   import oam_dma_pkg::*;
#(
   parameter logic [15:0] OAM_DATA = OAM_DATA_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,      // capture page_in, clear idx
   input  logic [7:0]  page_in,
   input  logic        inc,       // advance idx (8-bit wrap)
   input  addr_sel_t   sel,       // address for the next cycle
   output logic [15:0] bus_a,
   output logic        last       // idx is on the final byte of the page
);

   logic [7:0]  page, page_nxt;
   logic [7:0]  idx, idx_nxt;
   logic [15:0] addr_nxt;

   // Next page/index, and the address built from them so that a fresh
   // index is already visible on the bus in the cycle it takes effect.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
      page_nxt = load ? page_in : page;
      idx_nxt  = load ? 8'h00 : (inc ? idx + 8'd1 : idx);
      addr_nxt = bus_a;
      case (sel)
         SEL_BASE: addr_nxt = {page_nxt, 8'h00};
         SEL_SRC:  addr_nxt = {page_nxt, idx_nxt};
         SEL_OAM:  addr_nxt = OAM_DATA;
         default:  addr_nxt = bus_a;
      endcase
   end

   // Page, index and bus address registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         page  <= 8'h00;
         idx   <= 8'h00;
         bus_a <= 16'h0000;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         page  <= page_nxt;
         idx   <= idx_nxt;
         bus_a <= addr_nxt;
      end
   end

   assign last = (idx == 8'hFF);

endmodule

// File: rtl/oam_dma.sv
// Sprite DMA: on a CPU write to the trigger register, stall the core and
// copy one 256-byte page into the PPU OAM data port, get/put on parity.
module oam_dma
   import oam_dma_pkg::*;
#(
   parameter logic [15:0] DMA_REG  = DMA_REG_DEF,
   parameter logic [15:0] OAM_DATA = OAM_DATA_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] cpu_a,
   input  logic [7:0]  cpu_d,
   input  logic        cpu_rw,
   input  logic [7:0]  bus_d_in,
   output logic        rdy,
   output logic        bus_own,
   output logic [15:0] bus_a,
   output logic [7:0]  bus_d_out,
   output logic        bus_rw
);

   state_t    state, state_nxt;
   logic      par;
   logic [7:0] latch, latch_nxt;
   logic      rdy_nxt, own_nxt, rw_nxt;
   logic      load, inc, last;
   addr_sel_t sel;
   logic      trigger;

   assign trigger = (cpu_rw == RW_W) && (cpu_a == DMA_REG);

   dma_addr_gen #(.OAM_DATA(OAM_DATA)) u_addr_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .page_in (cpu_d),
      .inc     (inc),
      .sel     (sel),
      .bus_a   (bus_a),
      .last    (last)
   );

   // Next-state logic; bus controls are computed for the cycle being entered.
   always_comb begin
      state_nxt = state;
      rdy_nxt   = rdy;
      own_nxt   = bus_own;
      rw_nxt    = bus_rw;
      latch_nxt = latch;
      load      = 1'b0;
      inc       = 1'b0;
      sel       = SEL_HOLD;
      case (state)
         IDLE: begin
            if (trigger) begin
               state_nxt = HALT;
               rdy_nxt   = 1'b0;
               own_nxt   = 1'b1;
               rw_nxt    = RW_R;
               load      = 1'b1;
               sel       = SEL_BASE;
            end
         end
         HALT: begin
            // A get must land on par=0: go straight to GET only if the
            // next cycle already has par=0.
            rw_nxt = RW_R;
            if (par) begin
               state_nxt = GET;
               sel       = SEL_SRC;
            end else begin
               state_nxt = ALIGN;
               sel       = SEL_BASE;
            end
         end
         ALIGN: begin
            state_nxt = GET;
            rw_nxt    = RW_R;
            sel       = SEL_SRC;
         end
         GET: begin
            state_nxt = PUT;
            latch_nxt = bus_d_in;
            rw_nxt    = RW_W;
            sel       = SEL_OAM;
         end
         PUT: begin
            inc    = 1'b1;
            rw_nxt = RW_R;
            if (last) begin
               state_nxt = IDLE;
               rdy_nxt   = 1'b1;
               own_nxt   = 1'b0;
            end else begin
               state_nxt = GET;
               sel       = SEL_SRC;
            end
         end
         default: begin
            state_nxt = IDLE;
            rdy_nxt   = 1'b1;
            own_nxt   = 1'b0;
            rw_nxt    = RW_R;
         end
      endcase
   end

   // State, parity, data latch and registered core/bus control outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         par     <= 1'b0;
         latch   <= 8'h00;
         rdy     <= 1'b1;
         bus_own <= 1'b0;
         bus_rw  <= RW_R;
      end else begin
         state   <= state_nxt;
         par     <= ~par;
         latch   <= latch_nxt;
         rdy     <= rdy_nxt;
         bus_own <= own_nxt;
         bus_rw  <= rw_nxt;
      end
   end

   // The latch flop drives the write data bus directly.
   assign bus_d_out = latch;

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: expected bus beats are queued when a DMA is
// triggered and compared against every cycle in which the DMA owns the bus.
module tb_oam_dma;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] cpu_a = 16'h0000;
   logic [7:0]  cpu_d = 8'h00;
   logic        cpu_rw = 1'b1;
   logic [7:0]  bus_d_in;
   logic        rdy, bus_own, bus_rw;
   logic [15:0] bus_a;
   logic [7:0]  bus_d_out;

   typedef struct {
      logic        rw;
      logic [15:0] a;
      logic [7:0]  d;
   } beat_t;

   beat_t       exp_q[$];
   logic [7:0]  mem [0:65535];
   logic        tb_par;
   int          checks = 0;
   int          errors = 0;
   int          puts   = 0;

   oam_dma dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_a     (cpu_a),
      .cpu_d     (cpu_d),
      .cpu_rw    (cpu_rw),
      .bus_d_in  (bus_d_in),
      .rdy       (rdy),
      .bus_own   (bus_own),
      .bus_a     (bus_a),
      .bus_d_out (bus_d_out),
      .bus_rw    (bus_rw)
   );

   always #5 clk = ~clk;

   // Asynchronous memory model on the DMA side.
   assign bus_d_in = mem[bus_a];

   // Reference parity: cleared by reset, toggles every rising edge.
   always @(posedge clk or negedge rst_n)
      if (!rst_n) tb_par <= 1'b0;
      else        tb_par <= ~tb_par;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Bus monitor: every owned cycle must match the next expected beat.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus_own) begin
            if (exp_q.size() == 0) begin
               check("unexpected_own", {31'd0, bus_own}, 32'd0);
            end else begin
               beat_t b;
               b = exp_q.pop_front();
               check("beat", {7'd0, bus_rw, bus_a, (bus_rw ? 8'h00 : bus_d_out)},
                     {7'd0, b.rw, b.a, (b.rw ? 8'h00 : b.d)});
               if (!bus_rw) puts++;
            end
         end else begin
            check("idle_rw", {31'd0, bus_rw}, 32'd1);
         end
      end
   end

   // Drive one write to the trigger register and queue the expected beats.
   // Returns the parity the DMA will see in HALT. Called at a negedge.
   task automatic dma_start(input logic [7:0] page, output logic halt_par);
      beat_t b;
      halt_par = ~tb_par;
      b.rw = 1'b1; b.a = {page, 8'h00}; b.d = 8'h00;
      exp_q.push_back(b);
      if (!halt_par) exp_q.push_back(b);
      for (int i = 0; i < 256; i++) begin
         b.rw = 1'b1; b.a = {page, i[7:0]}; b.d = 8'h00;
         exp_q.push_back(b);
         b.rw = 1'b0; b.a = 16'h2004; b.d = mem[{page, i[7:0]}];
         exp_q.push_back(b);
      end
      cpu_rw = 1'b0; cpu_a = 16'h4014; cpu_d = page;
      @(negedge clk);
      cpu_rw = 1'b1; cpu_a = 16'h0000; cpu_d = 8'h00;
   endtask

   // Count stall cycles until rdy returns, then check length and scoreboard.
   task automatic dma_finish(input logic halt_par, input string tag);
      int stall = 0;
      while (rdy == 1'b0 && stall < 1000) begin
         stall++;
         @(negedge clk);
      end
      check({tag, "_stall"}, stall, halt_par ? 32'd513 : 32'd514);
      check({tag, "_q_empty"}, exp_q.size(), 32'd0);
      exp_q.delete();
   endtask

   task automatic dma_aligned(input logic [7:0] page, input logic want_par, input string tag);
      logic hp;
      int guard = 0;
      while (tb_par !== ~want_par && guard < 4) begin
         guard++;
         @(negedge clk);
      end
      dma_start(page, hp);
      check({tag, "_halt_par"}, {31'd0, hp}, {31'd0, want_par});
      dma_finish(hp, tag);
   endtask

   task automatic idle_cycles(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check({tag, "_rdy"}, {31'd0, rdy}, 32'd1);
         check({tag, "_own"}, {31'd0, bus_own}, 32'd0);
      end
   endtask

   initial begin
      logic hp, hp2;
      int   base, guard;

      for (int i = 0; i < 65536; i++) mem[i] = i[7:0] ^ i[15:8] ^ 8'h5A;
      for (int i = 0; i < 256; i++)   mem[16'hFF00 + i] = ~i[7:0];

      // Reset values.
      repeat (2) @(negedge clk);
      check("rst_rdy", {31'd0, rdy}, 32'd1);
      check("rst_own", {31'd0, bus_own}, 32'd0);
      check("rst_a", {16'd0, bus_a}, 32'd0);
      check("rst_dout", {24'd0, bus_d_out}, 32'd0);
      check("rst_rw", {31'd0, bus_rw}, 32'd1);
      rst_n = 1'b1;

      // Core reads only: nothing happens.
      idle_cycles(20, "idle");

      // Trigger page 2 with par=1 in HALT, then par=0 in HALT.
      dma_aligned(8'h02, 1'b1, "p2_par1");
      idle_cycles(3, "gap1");
      dma_aligned(8'h02, 1'b0, "p2_par0");
      idle_cycles(3, "gap2");

      // Top page: last source $FFFF carries 8'h00; next DMA restarts at idx 0.
      dma_aligned(8'hFF, 1'b1, "pFF");
      check("pFF_last_d", {24'd0, bus_d_out}, 32'd0);
      check("pFF_rdy_back", {31'd0, rdy}, 32'd1);
      idle_cycles(2, "gap3");
      dma_aligned(8'h02, 1'b1, "p2_after_FF");

      // Reset in the middle of the PUT for idx 8'h40.
      idle_cycles(2, "gap4");
      base = puts;
      dma_start(8'h05, hp);
      guard = 0;
      while (puts - base != 'h41 && guard < 400) begin
         @(negedge clk);
         #1;
         guard++;
      end
      check("mid_reached", puts - base, 32'h41);
      check("mid_is_put", {31'd0, bus_rw}, 32'd0);
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      check("mid_rst_rdy", {31'd0, rdy}, 32'd1);
      check("mid_rst_own", {31'd0, bus_own}, 32'd0);
      check("mid_rst_rw", {31'd0, bus_rw}, 32'd1);
      check("mid_rst_a", {16'd0, bus_a}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      base = puts;
      idle_cycles(10, "post_rst");
      check("post_rst_puts", puts - base, 32'd0);
      dma_aligned(8'h03, 1'b1, "p3_after_rst");

      // Read of the trigger register and write to the next address: no stall.
      @(negedge clk);
      cpu_rw = 1'b1; cpu_a = 16'h4014; cpu_d = 8'h07;
      @(negedge clk);
      cpu_rw = 1'b0; cpu_a = 16'h4015; cpu_d = 8'h07;
      @(negedge clk);
      cpu_rw = 1'b1; cpu_a = 16'h0000; cpu_d = 8'h00;
      check("nontrig_rdy", {31'd0, rdy}, 32'd1);
      idle_cycles(5, "nontrig");

      // Back-to-back: second trigger in the first idle cycle after return.
      base = puts;
      dma_start(8'h10, hp);
      dma_finish(hp, "b2b_1");
      dma_start(8'h11, hp2);
      dma_finish(hp2, "b2b_2");
      check("b2b_puts", puts - base, 32'd512);
      idle_cycles(3, "tail");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time bound so the bench always terminates.
   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation exceeded time limit");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $finish;
   end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Sprite DMA engine on the CPU-side bus, directly downstream of the 6502 core.
- Snoops core address/data/rw for a write to the DMA trigger register. It then stalls the core via rdy, takes the bus, and copies one 256-byte CPU page into the PPU OAM data port.
- Bus mux select (bus_own) tells the board-level mux whether the core or this block drives a/d/rw.

Parameters:
- DMA_REG, 16'h4014, trigger register address; written byte = source page.
- OAM_DATA, 16'h2004, destination address for every write cycle.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_a  in  16  core address bus.
- cpu_d  in  8  core write data (valid when cpu_rw=0).
- cpu_rw  in  1  core read/write; 1=read, 0=write.
- bus_d_in  in  8  read data returned from the memory system.
- rdy  out  1  1=core may advance; 0=core freezes all state.
- bus_own  out  1  1=this block drives bus_a/bus_d_out/bus_rw.
- bus_a  out  16  DMA address.
- bus_d_out  out  8  DMA write data.
- bus_rw  out  1  DMA read/write; 1=read.

Behaviour:
- Reset values of all outputs are registered:
  - rdy=1, bus_own=0, bus_a=0, bus_d_out=0, bus_rw=1.
- Reset values of internal state:
  - state=IDLE, page=0, idx=0, latch=0, par=0.
- par: free-running parity flop, toggles every clk. Read (get) cycles occur only when par=0; write (put) cycles only when par=1.
- States: IDLE, HALT, ALIGN, GET, PUT.
- IDLE:
  - Trigger is cpu_rw=0 && cpu_a==DMA_REG, sampled at a rising edge.
  - On trigger: page<=cpu_d, idx<=0, state<=HALT.
  - In the same edge: rdy<=0, bus_own<=1.
- HALT (1 cycle):
  - Dummy read: bus_a={page,8'h00}, bus_rw=1; data ignored.
  - Exit to GET if par==1 during HALT, else to ALIGN.
- ALIGN (1 cycle):
  - Same dummy read as HALT, then GET.
- GET:
  - bus_a={page,idx}, bus_rw=1.
  - latch<=bus_d_in at the end of the cycle; then PUT.
- PUT:
  - bus_a=OAM_DATA, bus_rw=0, bus_d_out=latch.
  - idx<=idx+1 (8-bit wrap).
  - If idx==8'hFF: state<=IDLE, and rdy<=1, bus_own<=0 at the same edge. Else state<=GET.
- Stall length (cycles with rdy=0):
  - 513 when par==1 in HALT.
  - 514 when par==0 in HALT.
  - rdy is low in the cycle immediately after the trigger write cycle.
- Source address never crosses the page: {page,idx} with idx 0..255. page=8'hFF reads $FF00-$FFFF.
- Trigger writes while not IDLE are ignored; the core is stalled, so a trigger can only appear through a faulty bench.
- Trigger write in the cycle after return to IDLE is accepted normally (back-to-back DMA).
- Only writes trigger: a read of DMA_REG does nothing, and a write to DMA_REG+1 does nothing.
- Reset asserted mid-transfer:
  - All outputs return to reset values immediately; the transfer is abandoned.
  - No further OAM writes after reset deassertion.
- All bus outputs are registered (no combinational path from cpu_* to bus_*). bus_a/bus_rw are valid for the whole cycle in which bus_own=1.
- While bus_own=0, bus_a/bus_d_out hold their last value, bus_rw=1.

Decomposition:
- Shared defines file (alongside the existing core defines):
  - state encodings (3-bit: IDLE, HALT, ALIGN, GET, PUT);
  - default DMA_REG/OAM_DATA addresses;
  - rw encoding constants (R=1, W=0), reused by the core.
- One sub-module is natural: dma_addr_gen. It holds the page register and idx counter, and produces bus_a from the state select (page base, page+idx, OAM_DATA) plus a last-byte flag.
- The FSM, parity flop and data latch stay in oam_dma.

Test Plan:
- Reset, then hold cpu_rw=1 for 20 cycles -> rdy=1, bus_own=0, bus_rw=1 throughout.
- Write 8'h02 to $4014 with par=1 at HALT:
  - rdy low for exactly 513 cycles.
  - GET addresses $0200..$02FF in order; 256 writes to $2004.
  - Each written byte equals the memory model byte at the preceding GET address.
- Same trigger shifted one cycle (par=0 at HALT) -> exactly 514 stall cycles, one ALIGN dummy read at $0200; data identical to the previous test.
- Page 8'hFF with memory[i]=~i[7:0] -> last GET at $FFFF, last PUT data 8'h00; idx wraps to 0; rdy returns 1 on the following cycle.
- Pulse rst_n low during the PUT for idx=8'h40, then release:
  - rdy=1 and bus_own=0 at once.
  - No $2004 write thereafter; a new trigger with 8'h03 completes all 256 bytes from $0300.
- Read of $4014 and write to $4015 -> no stall. Two triggers separated by a single idle cycle -> two complete transfers, 256 writes each.
